// File: rtl/c17_wave_scheduler.sv
// Issue scheduler, DEPTH-stage balanced pipeline and result FIFO around the c17 datapath.
// Issue is gated by credits so a result always has a FIFO slot waiting for it.
module c17_wave_scheduler #(
  parameter int DEPTH      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [4:0] in_vec,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_vec,
  input  logic       out_ready,
  output logic [4:0] inflight,
  output logic [4:0] fifo_count,
  output logic       idle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [4:0]                  credits;
  logic [DEPTH:1]              vld_pipe;
  logic [DEPTH:1][1:0]         dat_pipe;
  logic [FIFO_DEPTH-1:0][1:0]  mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        accept, pop, wr;
  logic                        n1, n2, n3, n6, n7, nand36;
  logic [1:0]                  c17_res;

  // c17 evaluated at issue: bit0 = N22, bit1 = N23
  always_comb begin
    {n7, n6, n3, n2, n1} = in_vec;
    nand36  = ~(n3 & n6);
    c17_res = {nand36 & (n2 | n7), (n1 & n3) | (n2 & nand36)};
  end

  assign in_ready  = (credits != 5'd0);
  assign out_valid = (fifo_count != 5'd0);
  assign out_vec   = out_valid ? mem[rd_ptr] : 2'b00;
  assign idle      = (inflight == 5'd0) && (fifo_count == 5'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr        = vld_pipe[DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_pipe   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= 5'd0;
      fifo_count <= 5'd0;
      credits    <= 5'(FIFO_DEPTH);
    end else begin
      vld_pipe[1] <= accept;
      dat_pipe[1] <= c17_res;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end

      // credit count guarantees the slot at wr_ptr is free here
      if (wr) begin
        mem[wr_ptr] <= dat_pipe[DEPTH];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({accept, pop})
        2'b10:   credits <= credits - 5'd1;
        2'b01:   credits <= credits + 5'd1;
        default: credits <= credits;
      endcase

      case ({accept, wr})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase

      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_wave_scheduler.sv
// Bench for c17_wave_scheduler: directed scenarios on the default build plus a
// randomized scoreboard run over three DEPTH/FIFO_DEPTH builds.
module tb_c17_wave_scheduler;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       in_valid   [3];
  logic [4:0] in_vec     [3];
  logic       in_ready   [3];
  logic       out_valid  [3];
  logic [1:0] out_vec    [3];
  logic       out_ready  [3];
  logic [4:0] inflight   [3];
  logic [4:0] fifo_count [3];
  logic       idle       [3];

  int n_pass, n_total;

  // scoreboard: per instance ring of (result, edge count at which it becomes visible)
  int         t;
  int         m_cnt  [3];
  int         m_head [3];
  int         m_av   [3][16];
  logic [1:0] m_res  [3][16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    c17_wave_scheduler #(
      .DEPTH     (g == 0 ? 4 : (g == 1 ? 1 : 7)),
      .FIFO_DEPTH(g == 0 ? 4 : (g == 1 ? 2 : 8))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid[g]),
      .in_vec    (in_vec[g]),
      .in_ready  (in_ready[g]),
      .out_valid (out_valid[g]),
      .out_vec   (out_vec[g]),
      .out_ready (out_ready[g]),
      .inflight  (inflight[g]),
      .fifo_count(fifo_count[g]),
      .idle      (idle[g])
    );
  end

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 7);
  endfunction

  function automatic int fdep_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 8);
  endfunction

  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n1, n2, n3, n6, n7;
    {n7, n6, n3, n2, n1} = v;
    return {~(n3 & n6) & (n2 | n7), (n1 & n3) | (n2 & ~(n3 & n6))};
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_vec[i]    = 5'd0;
      out_ready[i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({in_ready[i], out_valid[i], out_vec[i], inflight[i], fifo_count[i], idle[i]} !==
          {1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1})
        $display("FAIL reset_state inst%0d got %b %b %b %0d %0d %b", i, in_ready[i], out_valid[i],
                 out_vec[i], inflight[i], fifo_count[i], idle[i]);
      else n_pass++;
    end
    // rst with a token in flight and in_valid still high discards everything
    in_valid[0] = 1'b1;
    in_vec[0]   = 5'b00010;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (inflight[0] !== 5'd1) $display("FAIL pre_reset_inflight got %0d want 1", inflight[0]);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    n_total++;
    if ({in_ready[0], out_valid[0], out_vec[0], inflight[0], fifo_count[0], idle[0]} !==
        {1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1})
      $display("FAIL reset_discard got %b %b %b %0d %0d %b", in_ready[0], out_valid[0], out_vec[0],
               inflight[0], fifo_count[0], idle[0]);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (out_valid[0] !== 1'b0) $display("FAIL reset_stale cycle%0d got out_valid=%b want 0", c, out_valid[0]);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [4:0] v   [5] = '{5'b00000, 5'b00010, 5'b11111, 5'b00101, 5'b10000};
    logic [1:0] exp [5] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10};
    out_ready[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if ({idle[0], in_ready[0]} !== 2'b11) $display("FAIL single_idle vec%0d got %b want 11", k, {idle[0], in_ready[0]});
      else n_pass++;
      in_valid[0] = 1'b1;
      in_vec[0]   = v[k];
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      n_total++;
      if (inflight[0] !== 5'd1) $display("FAIL single_inflight vec%0d got %0d want 1", k, inflight[0]);
      else n_pass++;
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (out_valid[0] !== (e == 4)) $display("FAIL single_latency vec%0d edge%0d got %b want %b", k, e, out_valid[0], (e == 4));
        else n_pass++;
      end
      n_total++;
      if ({out_vec[0], fifo_count[0], inflight[0]} !== {exp[k], 5'd1, 5'd0})
        $display("FAIL single_result vec%0d got %b/%0d/%0d want %b/1/0", k, out_vec[0], fifo_count[0], inflight[0], exp[k]);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    n_total++;
    if (idle[0] !== 1'b1) $display("FAIL single_final_idle got %b want 1", idle[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int         acc_edge [8] = '{0, 1, 2, 3, 6, 7, 8, 9};
    logic [4:0] v [8];
    int         idx  = 0;
    int         npop = 0;
    for (int i = 0; i < 8; i++) v[i] = 5'(i * 4 + 1);
    out_ready[0] = 1'b1;
    for (int c = 0; c < 25; c++) begin
      n_total++;
      if (in_ready[0] !== ((inflight[0] + fifo_count[0]) < 5'd4))
        $display("FAIL b2b_credit cycle%0d got in_ready=%b inflight=%0d fifo=%0d", c, in_ready[0], inflight[0], fifo_count[0]);
      else n_pass++;
      if (out_valid[0]) begin
        n_total++;
        if (npop >= 8) $display("FAIL b2b_extra_output cycle%0d got %b want none", c, out_vec[0]);
        else if (out_vec[0] !== c17(v[npop])) $display("FAIL b2b_order pop%0d got %b want %b", npop, out_vec[0], c17(v[npop]));
        else n_pass++;
        npop++;
      end
      if (idx < 8) begin
        in_valid[0] = 1'b1;
        in_vec[0]   = v[idx];
        if (in_ready[0]) begin
          n_total++;
          if (c !== acc_edge[idx]) $display("FAIL b2b_accept_edge vec%0d got %0d want %0d", idx, c, acc_edge[idx]);
          else n_pass++;
          idx++;
        end
      end else in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    n_total++;
    if ({idx, npop} !== {32'd8, 32'd8}) $display("FAIL b2b_totals got acc=%0d pop=%0d want 8/8", idx, npop);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [4:0] v [5] = '{5'b00010, 5'b11111, 5'b00101, 5'b10000, 5'b01010};
    int idx = 0;
    int extra = 0;
    out_ready[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c >= 8) begin
        n_total++;
        if ({out_valid[0], out_vec[0], in_ready[0], fifo_count[0]} !== {1'b1, c17(v[0]), 1'b0, 5'd4})
          $display("FAIL bp_full cycle%0d got %b %b %b %0d", c, out_valid[0], out_vec[0], in_ready[0], fifo_count[0]);
        else n_pass++;
      end
      in_valid[0] = 1'b1;
      in_vec[0]   = (idx < 4) ? v[idx] : v[4];
      if (in_ready[0]) begin
        if (idx < 4) idx++;
        else extra++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    n_total++;
    if ({idx, extra} !== {32'd4, 32'd0}) $display("FAIL bp_accepts got %0d/%0d want 4/0", idx, extra);
    else n_pass++;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if ({out_valid[0], out_vec[0], in_ready[0]} !== {1'b1, c17(v[k]), (k != 0)})
        $display("FAIL bp_drain pop%0d got %b %b %b want 1 %b %b", k, out_valid[0], out_vec[0], in_ready[0], c17(v[k]), (k != 0));
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    n_total++;
    if ({idle[0], in_ready[0]} !== 2'b11) $display("FAIL bp_end got %b want 11", {idle[0], in_ready[0]});
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [3:0] sched = 4'b1101;
    out_ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = (c < 4) ? sched[c] : 1'b0;
      in_vec[0]   = 5'(c + 2);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    n_total++;
    if ({inflight[0], fifo_count[0], out_valid[0]} !== {5'd2, 5'd1, 1'b1})
      $display("FAIL flush_setup got %0d/%0d/%b want 2/1/1", inflight[0], fifo_count[0], out_valid[0]);
    else n_pass++;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    n_total++;
    if ({out_valid[0], out_vec[0], inflight[0], fifo_count[0], in_ready[0], idle[0]} !==
        {1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 1'b1})
      $display("FAIL flush_state got %b %b %0d %0d %b %b", out_valid[0], out_vec[0], inflight[0],
               fifo_count[0], in_ready[0], idle[0]);
    else n_pass++;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (out_valid[0] !== 1'b0) $display("FAIL flush_stale cycle%0d got %b want 0", c, out_valid[0]);
      else n_pass++;
    end
    in_valid[0] = 1'b1;
    in_vec[0]   = 5'b00101;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_total++;
    if ({out_valid[0], out_vec[0]} !== {1'b1, 2'b01}) $display("FAIL flush_next got %b %b want 1 01", out_valid[0], out_vec[0]);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random(input int ncyc);
    logic acc [3];
    logic pop [3];
    do_reset();
    t = 0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_head[i] = 0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      int pv, pr;
      // alternate bias phases so the FIFO both fills up and runs dry
      pv = ((cyc / 500) % 2 == 0) ? 80 : 30;
      pr = ((cyc / 700) % 2 == 0) ? 25 : 85;
      for (int i = 0; i < 3; i++) begin
        int inf, ff, hk;
        logic e_ov, e_ir;
        logic [1:0] e_vec;
        inf = 0;
        ff  = 0;
        for (int j = 0; j < m_cnt[i]; j++) begin
          if (m_av[i][(m_head[i] + j) % 16] <= t) ff++;
          else inf++;
        end
        hk    = m_head[i];
        e_ov  = (m_cnt[i] > 0) && (m_av[i][hk] <= t);
        e_ir  = (m_cnt[i] < fdep_of(i));
        e_vec = e_ov ? m_res[i][hk] : 2'b00;
        n_total++;
        if ({in_ready[i], out_valid[i], out_vec[i], inflight[i], fifo_count[i], idle[i]} !==
            {e_ir, e_ov, e_vec, 5'(inf), 5'(ff), (inf == 0 && ff == 0)})
          $display("FAIL rand inst%0d cyc%0d got rdy=%b ov=%b vec=%b inf=%0d cnt=%0d idle=%b want %b %b %b %0d %0d",
                   i, cyc, in_ready[i], out_valid[i], out_vec[i], inflight[i], fifo_count[i], idle[i],
                   e_ir, e_ov, e_vec, inf, ff);
        else n_pass++;
        n_total++;
        if (fifo_count[i] > 5'(fdep_of(i))) $display("FAIL rand_overflow inst%0d got %0d max %0d", i, fifo_count[i], fdep_of(i));
        else n_pass++;
        in_valid[i]  = ($urandom_range(0, 99) < pv);
        in_vec[i]    = 5'($urandom_range(0, 31));
        out_ready[i] = ($urandom_range(0, 99) < pr);
        acc[i] = in_valid[i] & e_ir;
        pop[i] = e_ov & out_ready[i];
      end
      @(posedge clk);
      t++;
      for (int i = 0; i < 3; i++) begin
        if (pop[i]) begin
          m_head[i] = (m_head[i] + 1) % 16;
          m_cnt[i]--;
        end
        if (acc[i]) begin
          m_res[i][(m_head[i] + m_cnt[i]) % 16] = c17(in_vec[i]);
          m_av[i][(m_head[i] + m_cnt[i]) % 16]  = t + depth_of(i);
          m_cnt[i]++;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random(10000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/c17_wave_scheduler.md
Name: c17_wave_scheduler

Overview:
- Issue scheduler and result buffer for the path-balanced c17 datapath.
- Accepts 5-bit input vectors over a valid/ready handshake and launches one vector per cycle into a DEPTH-stage clocked pipeline. Every stage is a registered buffer level, so all paths are balanced.
- Tracks which stages hold valid tokens and captures results into an output FIFO.
- Credit-based issue gating guarantees no result is ever dropped.
- Sits between the stimulus/host interface and the c17 datapath. The c17 logic is evaluated inside this block.

Parameters:
- DEPTH, 4, number of pipeline stages from issue to FIFO write (legal range 1..16).
- FIFO_DEPTH, 4, output FIFO entries; also the initial credit count (legal range 2..16, power of two).

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of the pipeline and FIFO; same effect as rst.
- in_valid  input  1  input vector valid.
- in_vec  input  5  bit0=N1, bit1=N2, bit2=N3, bit3=N6, bit4=N7.
- in_ready  output  1  scheduler can accept a vector this cycle.
- out_valid  output  1  FIFO head holds a result.
- out_vec  output  2  bit0=N22, bit1=N23 of the FIFO head.
- out_ready  input  1  consumer accepts the head.
- inflight  output  5  count of valid tokens in the pipeline stages.
- fifo_count  output  5  FIFO occupancy.
- idle  output  1  high when inflight==0 and fifo_count==0.

Behaviour:
- Function:
  - N22 = (N1&N3) | (N2&~(N3&N6)).
  - N23 = ~(N3&N6) & (N2|N7).
  - Compute at issue; carry the result through DEPTH registered stages, each with a valid bit.
- Reset / flush (rst or flush high at an edge):
  - All stage valid bits cleared; FIFO pointers and count zeroed; credits set to FIFO_DEPTH.
  - Outputs after the edge: in_ready=1, out_valid=0, out_vec=0, inflight=0, fifo_count=0, idle=1.
  - Tokens in flight at that edge are discarded. rst takes priority over all other events.
- Credits:
  - in_ready = (credits != 0); purely a function of registered state, no combinational path from in_valid.
  - Accept = in_valid & in_ready: credits -1.
  - Pop = out_valid & out_ready: credits +1.
  - Accept and pop at the same edge: credits unchanged.
  - Invariant: credits + inflight + fifo_count == FIFO_DEPTH at all times.
- Pipeline:
  - Never stalls; the valid bit and data advance one stage per edge.
  - Accept at edge 0 loads stage 1; stage DEPTH is loaded at edge DEPTH-1.
  - At edge DEPTH the token is written to the FIFO tail. out_valid is visible in the cycle after edge DEPTH if the FIFO was empty.
  - Bubbles (no accept) propagate as invalid stages and produce no FIFO write.
- FIFO:
  - Write and pop at the same edge are both performed; fifo_count is unchanged.
  - Write into a full FIFO is impossible by the credit invariant. The bench asserts this.
  - out_vec is held stable while out_valid & ~out_ready.
  - Order is strictly FIFO: results emerge in acceptance order.
- Counters:
  - inflight: +1 on accept, -1 on FIFO write; both at the same edge leaves it unchanged.
  - fifo_count: +1 on write, -1 on pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Throughput (default config, out_ready held 1): 4 accepts per 6 cycles, at edges 0,1,2,3, then 6,7,8,9, and so on.

Test Plan:
- Reset, then single vectors 5'b00000, 5'b00010, 5'b11111, 5'b00101, 5'b10000, each followed by idle cycles -> out_vec 2'b00, 2'b11, 2'b01, 2'b01, 2'b10. Each out_valid appears in the cycle after the 4th edge following acceptance; idle=1 between vectors.
- in_valid held 1 with 8 distinct vectors, out_ready=1 -> accepts at edges 0,1,2,3,6,7,8,9; in_ready low during cycles 4–5; results in order; credit invariant holds every cycle.
- out_ready=0 while 4 vectors are sent -> fifo_count reaches 4; in_ready=0; further in_valid is not accepted; out_vec stable. Release out_ready -> 4 pops in order; in_ready returns 1 the cycle after the first pop.
- Assert flush with 2 tokens inflight and 1 in the FIFO -> next cycle out_valid=0, inflight=0, fifo_count=0, in_ready=1. No stale results ever appear; the next vector returns the correct value.
- Random in_valid/out_ready (10k cycles) against a scoreboard of the c17 equations -> no loss, duplication or reordering. Repeat with DEPTH=1 and DEPTH=7, FIFO_DEPTH=2 and 8.
